// File: rtl/dct_pkg.sv
// rtl/dct_pkg.sv - shared types, widths and cosine tables for the 2D DCT
package dct_pkg;

  typedef enum logic [1:0] {ST_LOAD, ST_ROW, ST_COL, ST_OUT} dct_state_e;

  // Tables are held at 14 fractional bits (COEF_W = 16) and rescaled on demand.
  localparam int BASE_FRAC = 14;

  // Quarter-wave magnitudes alpha(k)*cos(m*pi/(2N)) * 2^14 for k > 0, m = 0..N.
  localparam int C4 [0:4] = '{11585, 10703, 8192, 4433, 0};
  localparam int C8 [0:8] = '{8192, 8035, 7568, 6811, 5793, 4551, 3135, 1598, 0};
  // k = 0 row uses alpha(0) = sqrt(1/N).
  localparam int C4_DC = 8192;
  localparam int C8_DC = 5793;

  // Width of the stored row-pass result; cannot overflow for an N-point orthonormal DCT.
  function automatic int mid_w(input int in_w, input int n);
    return in_w + $clog2(n) + 1;
  endfunction

  // Accumulator width for an N-term dot product of data_w samples by coef_w coefficients.
  function automatic int acc_w(input int data_w, input int coef_w, input int n);
    return data_w + coef_w + $clog2(n);
  endfunction

  // Coefficient C[k][n] at 'frac' fractional bits, folded out of the quarter-wave table.
  function automatic int dct_coef(input int n_sz, input int k, input int n, input int frac);
    int m;
    int v;
    int sh;
    bit neg;
    neg = 1'b0;
    if (n_sz == 4) begin
      m = ((2 * n + 1) * k) % 16;
      if (m > 8) m = 16 - m;
      if (m > 4) begin
        m   = 8 - m;
        neg = 1'b1;
      end
      v = (k == 0) ? C4_DC : C4[m];
    end else begin
      m = ((2 * n + 1) * k) % 32;
      if (m > 16) m = 32 - m;
      if (m > 8) begin
        m   = 16 - m;
        neg = 1'b1;
      end
      v = (k == 0) ? C8_DC : C8[m];
    end
    // Rescale the magnitude so rounding stays half-away-from-zero after negation.
    if (frac < BASE_FRAC) begin
      sh = BASE_FRAC - frac;
      v  = (v + (1 << (sh - 1))) >>> sh;
    end else begin
      v = v <<< (frac - BASE_FRAC);
    end
    return neg ? -v : v;
  endfunction

endpackage

// File: rtl/dct_2d_param_if.sv
// rtl/dct_2d_param_if.sv - row-stream handshake bundle between producer, DCT and consumer
interface dct_2d_param_if #(
  parameter int N     = 8,
  parameter int IN_W  = 9,
  parameter int OUT_W = 12
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [N*IN_W-1:0]    in_row;
  logic                 out_valid;
  logic                 out_ready;
  logic [N*OUT_W-1:0]   out_row;
  logic                 sat_flag;
  logic                 busy;

  modport master (
    output flush, in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_row, sat_flag, busy
  );

  modport slave (
    input  flush, in_valid, in_row, out_ready,
    output in_ready, out_valid, out_row, sat_flag, busy
  );
endinterface

// File: rtl/dct_1d.sv
// rtl/dct_1d.sv - combinational N-term dot product with round-half-up shift
module dct_1d #(
  parameter int N      = 8,
  parameter int DATA_W = 13,
  parameter int COEF_W = 16,
  parameter int FRAC   = 14,
  parameter int ACC_W  = 32
) (
  input  logic [N*DATA_W-1:0]          x,
  input  logic [N*COEF_W-1:0]          coef,
  output logic signed [ACC_W-FRAC-1:0] y
);

  localparam logic signed [ACC_W-1:0] HALF = ACC_W'(1) << (FRAC - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] rnd;

  // Sign-extend each term to the accumulator width, sum, then round and drop the fraction.
  always_comb begin
    acc = '0;
    for (int n = 0; n < N; n++) begin
      acc = acc + ACC_W'($signed(x[n*DATA_W +: DATA_W])) * ACC_W'($signed(coef[n*COEF_W +: COEF_W]));
    end
    rnd = acc + HALF;
    y   = rnd[ACC_W-1:FRAC];
  end

endmodule

// File: rtl/dct_2d_param.sv
// rtl/dct_2d_param.sv - block 2D DCT-II: load, row pass, column pass, drain
module dct_2d_param
  import dct_pkg::*;
#(
  parameter int N      = 8,
  parameter int IN_W   = 9,
  parameter int COEF_W = 16,
  parameter int OUT_W  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  dct_2d_param_if.slave      bus
);

  localparam int L     = $clog2(N);
  localparam int FRAC  = COEF_W - 2;
  localparam int MID_W = mid_w(IN_W, N);
  localparam int ACC_W = acc_w(MID_W, COEF_W, N);
  localparam int RES_W = ACC_W - FRAC;

  dct_state_e          state;
  logic [L-1:0]        row_cnt;
  logic [2*L-1:0]      op_cnt;
  logic                in_ready_q;
  logic                out_valid_q;
  logic                sat_q;
  logic                busy_q;

  logic signed [IN_W-1:0]  in_buf  [N][N];
  logic signed [MID_W-1:0] mid_buf [N][N];
  logic signed [OUT_W-1:0] res_buf [N][N];

  logic [L-1:0]            hi;
  logic [L-1:0]            lo;
  logic                    op_last;
  logic                    in_fire;
  logic                    out_fire;
  logic [N*MID_W-1:0]      x_vec;
  logic [N*COEF_W-1:0]     c_vec;
  logic signed [RES_W-1:0] dot_y;
  logic                    clip_hi;
  logic                    clip_lo;
  logic signed [OUT_W-1:0] col_val;
  logic [N*OUT_W-1:0]      out_row_c;

  // op_cnt splits as {hi, lo}: hi picks the data row, lo picks the coefficient row.
  assign hi       = op_cnt[2*L-1:L];
  assign lo       = op_cnt[L-1:0];
  assign op_last  = (op_cnt == (2*L)'(N * N - 1));
  assign in_fire  = bus.in_valid & in_ready_q & ~bus.flush;
  assign out_fire = bus.out_ready & out_valid_q & ~bus.flush;

  // Feed the shared dot product: input rows during ROW, transposed mid rows during COL.
  always_comb begin
    x_vec = '0;
    c_vec = '0;
    for (int n = 0; n < N; n++) begin
      if (state == ST_COL) x_vec[n*MID_W +: MID_W] = mid_buf[hi][n];
      else                 x_vec[n*MID_W +: MID_W] = MID_W'(in_buf[hi][n]);
      c_vec[n*COEF_W +: COEF_W] = COEF_W'(dct_coef(N, int'(lo), n, FRAC));
    end
  end

  dct_1d #(
    .N      (N),
    .DATA_W (MID_W),
    .COEF_W (COEF_W),
    .FRAC   (FRAC),
    .ACC_W  (ACC_W)
  ) u_dot (
    .x    (x_vec),
    .coef (c_vec),
    .y    (dot_y)
  );

  // Column results clip to the output range; any bit above the sign that disagrees means overflow.
  always_comb begin
    clip_hi = ~dot_y[RES_W-1] & (|dot_y[RES_W-2:OUT_W-1]);
    clip_lo =  dot_y[RES_W-1] & ~(&dot_y[RES_W-2:OUT_W-1]);
    if (clip_hi)      col_val = {1'b0, {(OUT_W-1){1'b1}}};
    else if (clip_lo) col_val = {1'b1, {(OUT_W-1){1'b0}}};
    else              col_val = dot_y[OUT_W-1:0];
  end

  // Data buffers carry no reset; ROW writes transposed so COL reads a plain row.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      for (int n = 0; n < N; n++) in_buf[row_cnt][n] <= bus.in_row[n*IN_W +: IN_W];
    end
    if (state == ST_ROW) mid_buf[lo][hi] <= dot_y[MID_W-1:0];
    if (state == ST_COL) res_buf[lo][hi] <= col_val;
  end

  // Block sequencer with registered handshake and status outputs; flush beats any handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_LOAD;
      row_cnt     <= '0;
      op_cnt      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else if (bus.flush) begin
      state       <= ST_LOAD;
      row_cnt     <= '0;
      op_cnt      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      sat_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            busy_q <= 1'b1;
            if (row_cnt == '0) sat_q <= 1'b0;
            if (row_cnt == L'(N - 1)) begin
              row_cnt    <= '0;
              in_ready_q <= 1'b0;
              state      <= ST_ROW;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        ST_ROW: begin
          op_cnt <= op_cnt + 1'b1;
          if (op_last) state <= ST_COL;
        end
        ST_COL: begin
          op_cnt <= op_cnt + 1'b1;
          if (clip_hi | clip_lo) sat_q <= 1'b1;
          if (op_last) begin
            state       <= ST_OUT;
            out_valid_q <= 1'b1;
          end
        end
        ST_OUT: begin
          if (out_fire) begin
            if (row_cnt == L'(N - 1)) begin
              row_cnt     <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
              state       <= ST_LOAD;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

  // Present the selected result row; forced to zero whenever no row is offered.
  always_comb begin
    out_row_c = '0;
    if (out_valid_q) begin
      for (int n = 0; n < N; n++) out_row_c[n*OUT_W +: OUT_W] = res_buf[row_cnt][n];
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_row   = out_row_c;
  assign bus.sat_flag  = sat_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_dct_2d_param.sv
// tb/tb_dct_2d_param.sv - directed and random block checks against a real-valued-coefficient model
module tb_dct_2d_param;

  logic clk;
  logic rst_n;

  dct_2d_param_if #(.N(8), .IN_W(9), .OUT_W(12)) bus ();
  dct_2d_param_if #(.N(8), .IN_W(9), .OUT_W(11)) bus_s ();

  dct_2d_param #(.N(8), .IN_W(9), .COEF_W(16), .OUT_W(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  dct_2d_param #(.N(8), .IN_W(9), .COEF_W(16), .OUT_W(11)) dut_s (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_s.slave)
  );

  assign bus_s.in_valid  = bus.in_valid;
  assign bus_s.in_row    = bus.in_row;
  assign bus_s.out_ready = bus.out_ready;
  assign bus_s.flush     = bus.flush;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_cyc = 0;
  int blk_id   = 0;

  int  coef_m [8][8];
  int  x_blk  [8][8];
  int  y_exp  [8][8];
  int  y_exp_s[8][8];
  bit  sat_m;
  bit  sat_s;

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic longint coef_at(input logic [95:0] row, input int n);
    return longint'($signed(row[n*12 +: 12]));
  endfunction

  function automatic longint coef_at_s(input logic [87:0] row, input int n);
    return longint'($signed(row[n*11 +: 11]));
  endfunction

  task automatic build_coefs();
    real a;
    real v;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < 8; n++) begin
        a = (k == 0) ? $sqrt(1.0 / 8.0) : $sqrt(2.0 / 8.0);
        v = a * $cos((2.0 * n + 1.0) * k * 3.14159265358979323846 / 16.0) * 16384.0;
        coef_m[k][n] = (v >= 0.0) ? int'($floor(v + 0.5)) : -int'($floor(-v + 0.5));
      end
    end
  endtask

  task automatic run_model();
    int     t[8][8];
    longint acc;
    longint v;
    sat_m = 1'b0;
    sat_s = 1'b0;
    for (int r = 0; r < 8; r++) begin
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int n = 0; n < 8; n++) acc += longint'(coef_m[k][n]) * x_blk[r][n];
        t[r][k] = int'((acc + 8192) >>> 14);
      end
    end
    for (int c = 0; c < 8; c++) begin
      for (int u = 0; u < 8; u++) begin
        acc = 0;
        for (int r = 0; r < 8; r++) acc += longint'(coef_m[u][r]) * t[r][c];
        v = (acc + 8192) >>> 14;
        if (v > 2047)       begin y_exp[u][c] = 2047;  sat_m = 1'b1; end
        else if (v < -2048) begin y_exp[u][c] = -2048; sat_m = 1'b1; end
        else                      y_exp[u][c] = int'(v);
        if (v > 1023)       begin y_exp_s[u][c] = 1023;  sat_s = 1'b1; end
        else if (v < -1024) begin y_exp_s[u][c] = -1024; sat_s = 1'b1; end
        else                      y_exp_s[u][c] = int'(v);
      end
    end
  endtask

  task automatic fill_const(input int val);
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) x_blk[r][n] = val;
  endtask

  task automatic fill_rand();
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) x_blk[r][n] = int'($urandom_range(511)) - 256;
  endtask

  task automatic drive_row(input int r);
    bus.in_valid = 1'b1;
    for (int n = 0; n < 8; n++) bus.in_row[n*9 +: 9] = 9'(x_blk[r][n]);
  endtask

  task automatic send_block();
    for (int r = 0; r < 8; r++) begin
      drive_row(r);
      chk($sformatf("in_ready b%0d r%0d", blk_id, r), bus.in_ready, 1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    last_cyc = cyc;
  endtask

  task automatic wait_valid();
    int t;
    t = 0;
    while (!bus.out_valid && t < 300) begin
      @(posedge clk); #1;
      t++;
    end
    chk($sformatf("latency b%0d", blk_id), cyc - last_cyc, 128);
  endtask

  task automatic recv_block(input int mode, input bit chk_s);
    int k;
    int t;
    bit rdy;
    k = 0;
    t = 0;
    while (k < 8 && t < 80) begin
      rdy = (mode == 0) ? 1'b1 : (t >= 5 && ((t - 5) % 2 == 1));
      bus.out_ready = rdy;
      chk($sformatf("out_valid b%0d r%0d", blk_id, k), bus.out_valid, 1);
      chk($sformatf("sat b%0d r%0d", blk_id, k), bus.sat_flag, sat_m);
      for (int n = 0; n < 8; n++) begin
        chk($sformatf("coef b%0d r%0d c%0d", blk_id, k, n), coef_at(bus.out_row, n), y_exp[k][n]);
        if (chk_s) chk($sformatf("coef11 b%0d r%0d c%0d", blk_id, k, n), coef_at_s(bus_s.out_row, n), y_exp_s[k][n]);
      end
      if (chk_s) chk($sformatf("sat11 b%0d r%0d", blk_id, k), bus_s.sat_flag, sat_s);
      @(posedge clk); #1;
      if (rdy) k++;
      t++;
    end
    bus.out_ready = 1'b0;
    chk($sformatf("rows b%0d", blk_id), k, 8);
    chk($sformatf("in_ready after last b%0d", blk_id), bus.in_ready, 1);
    chk($sformatf("out_valid after last b%0d", blk_id), bus.out_valid, 0);
    chk($sformatf("busy after last b%0d", blk_id), bus.busy, 0);
    blk_id++;
  endtask

  task automatic start_block();
    run_model();
    send_block();
    wait_valid();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " in_ready"}, bus.in_ready, 1);
    chk({tag, " out_valid"}, bus.out_valid, 0);
    chk({tag, " sat_flag"}, bus.sat_flag, 0);
    chk({tag, " busy"}, bus.busy, 0);
    chk({tag, " out_row"}, (bus.out_row == '0) ? 1 : 0, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clk           = 1'b0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;
    build_coefs();

    #12;
    chk_idle("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Constant 100 with stalled, then toggling, out_ready.
    fill_const(100);
    start_block();
    chk("dc100", coef_at(bus.out_row, 0), 800);
    chk("ac100", coef_at(bus.out_row, 1), 0);
    chk("sat100", bus.sat_flag, 0);
    recv_block(1, 1'b0);

    // Most negative constant: DC reaches the bottom of the 12-bit range without clipping.
    fill_const(-256);
    start_block();
    chk("dc_neg", coef_at(bus.out_row, 0), -2048);
    chk("sat_neg", bus.sat_flag, 0);
    recv_block(0, 1'b0);

    // Constant 255: fits in 12 bits, clips in the 11-bit instance.
    fill_const(255);
    start_block();
    chk("dc255", coef_at(bus.out_row, 0), 2039);
    chk("dc255_11", coef_at_s(bus_s.out_row, 0), 1023);
    chk("sat255_11", bus_s.sat_flag, 1);
    recv_block(0, 1'b1);
    chk("sat held in load", bus_s.sat_flag, 1);

    // First row of the next block clears sat; flush on the 4th row aborts the block.
    fill_rand();
    for (int r = 0; r < 3; r++) begin
      drive_row(r);
      @(posedge clk); #1;
      if (r == 0) begin
        chk("sat cleared on row0", bus_s.sat_flag, 0);
        chk("busy after row0", bus.busy, 1);
      end
    end
    drive_row(3);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    chk_idle("flush");
    @(posedge clk); #1;
    fill_rand();
    start_block();
    recv_block(0, 1'b1);

    // Reset pulse in the middle of the column pass.
    fill_rand();
    send_block();
    repeat (74) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_idle("reset midcol");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_idle("after reset");
    fill_rand();
    start_block();
    recv_block(0, 1'b1);

    // Back-to-back random blocks.
    for (int b = 0; b < 50; b++) begin
      fill_rand();
      start_block();
      recv_block(0, 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
